// File: rtl/i2c_seq_pkg.sv
// Shared types for the I2C command sequencer: FSM state and FIFO command word.
package i2c_seq_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      BUSY,
      RESP
   } state_t;

   // One queued transaction request; this is the FIFO word (16 bits).
   typedef struct packed {
      logic [6:0] addr;
      logic       rw;
      logic [7:0] wdata;
   } cmd_t;

endpackage

// File: rtl/i2c_cmd_fifo.sv
// Synchronous command FIFO with a first-word-fall-through head.
// DEPTH must be a power of two so the pointers wrap without extra logic.
module i2c_cmd_fifo
   import i2c_seq_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push_i,
   input  cmd_t        wdata_i,
   input  logic        pop_i,
   output cmd_t        rdata_o,
   output logic        full_o,
   output logic        empty_o,
   output logic [AW:0] count_o
);

   cmd_t          mem_q [DEPTH];
   logic [AW-1:0] wr_q;
   logic [AW-1:0] rd_q;
   logic [AW:0]   cnt_q;
   logic          do_push;
   logic          do_pop;

   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign rdata_o = mem_q[rd_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Storage needs no reset; occupancy decides what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= wdata_i;
   end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Command front end for the I2C master: queues requests, issues them one at a
// time over the enable/ready handshake and returns one response per command.
module i2c_cmd_sequencer
   import i2c_seq_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 1024
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [6:0] cmd_addr,
   input  logic       cmd_rw,
   input  logic [7:0] cmd_wdata,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [6:0] rsp_addr,
   output logic [7:0] rsp_rdata,
   output logic       rsp_timeout,
   output logic [6:0] i2c_addr,
   output logic       i2c_rw,
   output logic [7:0] i2c_data_in,
   output logic       i2c_enable,
   input  logic       i2c_ready,
   input  logic [7:0] i2c_data_out,
   output logic       busy
);

   localparam int             CW   = $clog2(TIMEOUT);
   localparam int             FCW  = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0]  TMAX = CW'(TIMEOUT - 1);

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic [CW-1:0]   cnt_d;
   logic [1:0]      sync_q;
   logic            ready_s;
   logic            enable_q;
   logic [6:0]      addr_q;
   logic            rw_q;
   logic [7:0]      data_q;
   logic            rsp_valid_q;
   logic [6:0]      rsp_addr_q;
   logic [7:0]      rsp_rdata_q;
   logic            rsp_to_q;
   cmd_t            push_word;
   cmd_t            head;
   logic            fifo_full;
   logic            fifo_empty;
   logic [FCW-1:0]  fifo_count;
   logic            pop;

   assign push_word = '{addr: cmd_addr, rw: cmd_rw, wdata: cmd_wdata};
   assign cmd_ready = !fifo_full;
   assign ready_s   = sync_q[1];
   // The head leaves the FIFO once the controller has taken it or it is abandoned.
   assign pop       = (state_q == ISSUE) && (!ready_s || (cnt_q == TMAX));
   assign cnt_d     = (cnt_q == TMAX) ? cnt_q : cnt_q + 1'b1;

   assign i2c_enable  = enable_q;
   assign i2c_addr    = addr_q;
   assign i2c_rw      = rw_q;
   assign i2c_data_in = data_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_addr    = rsp_addr_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_timeout = rsp_to_q;
   assign busy        = (state_q != IDLE) || (fifo_count != '0);

   i2c_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (cmd_valid),
      .wdata_i (push_word),
      .pop_i   (pop),
      .rdata_o (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // Bring the controller's ready into the system clock domain; idles high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= 2'b11;
      else     sync_q <= {sync_q[0], i2c_ready};
   end

   // Issue/response FSM with timeout counter and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         enable_q    <= 1'b0;
         addr_q      <= '0;
         rw_q        <= 1'b0;
         data_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_addr_q  <= '0;
         rsp_rdata_q <= '0;
         rsp_to_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!fifo_empty && ready_s) begin
                  state_q  <= ISSUE;
                  enable_q <= 1'b1;
                  addr_q   <= head.addr;
                  rw_q     <= head.rw;
                  data_q   <= head.wdata;
                  cnt_q    <= '0;
               end
            end
            ISSUE: begin
               cnt_q <= cnt_d;
               if (!ready_s) begin
                  state_q  <= BUSY;
                  enable_q <= 1'b0;
               end else if (cnt_q == TMAX) begin
                  state_q     <= RESP;
                  enable_q    <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_addr_q  <= addr_q;
                  rsp_rdata_q <= '0;
                  rsp_to_q    <= 1'b1;
               end
            end
            BUSY: begin
               cnt_q <= cnt_d;
               if (ready_s) begin
                  state_q     <= RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_addr_q  <= addr_q;
                  rsp_rdata_q <= rw_q ? i2c_data_out : 8'h00;
                  rsp_to_q    <= 1'b0;
               end else if (cnt_q == TMAX) begin
                  state_q     <= RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_addr_q  <= addr_q;
                  rsp_rdata_q <= '0;
                  rsp_to_q    <= 1'b1;
               end
            end
            RESP: begin
               // Drop valid on the handshake, then spend one settle cycle
               // before returning to IDLE.
               if (rsp_valid_q) begin
                  if (rsp_ready) rsp_valid_q <= 1'b0;
               end else begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Scoreboard bench: commands push expectations, a controller model serves
// issues in order, and a monitor checks every response the DUT presents.
module tb_i2c_cmd_sequencer;

   localparam int TO = 120;
   localparam int FD = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid, cmd_ready, cmd_rw;
   logic [6:0] cmd_addr;
   logic [7:0] cmd_wdata;
   logic       rsp_valid, rsp_ready, rsp_timeout;
   logic [6:0] rsp_addr;
   logic [7:0] rsp_rdata;
   logic [6:0] i2c_addr;
   logic       i2c_rw, i2c_enable, i2c_ready, busy;
   logic [7:0] i2c_data_in, i2c_data_out;

   i2c_cmd_sequencer #(.FIFO_DEPTH(FD), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
      .cmd_rw(cmd_rw), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
      .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
      .i2c_addr(i2c_addr), .i2c_rw(i2c_rw), .i2c_data_in(i2c_data_in),
      .i2c_enable(i2c_enable), .i2c_ready(i2c_ready),
      .i2c_data_out(i2c_data_out), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0] addr;
      bit         rw;
      logic [7:0] wd;
      bit         ign;   // controller never takes it -> timeout
      logic [7:0] dat;   // byte the controller returns
      int         low;   // cycles ready stays low
   } plan_t;

   typedef struct {
      logic [6:0] addr;
      logic [7:0] rdata;
      bit         to;
   } exp_t;

   plan_t plan_q[$];
   exp_t  exp_q[$];

   int tests = 0, fails = 0;
   int cyc = 0;
   int en_rise = -1, en_fall = -1, rf = -1, hs_cyc = -1, rsp_cnt = 0;
   int rsp_mode = 0;  // 0 random, 1 stall, 2 always ready

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Record a command's expected response and the controller's behaviour.
   task automatic expect_cmd(input logic [6:0] a, input bit rw, input logic [7:0] wd,
                             input bit ign, input logic [7:0] dat, input int low);
      plan_t p;
      exp_t  e;
      p.addr = a; p.rw = rw; p.wd = wd; p.ign = ign; p.dat = dat; p.low = low;
      e.addr = a; e.to = ign;
      e.rdata = (ign || !rw) ? 8'h00 : dat;
      plan_q.push_back(p);
      exp_q.push_back(e);
   endtask

   task automatic push(input logic [6:0] a, input bit rw, input logic [7:0] wd,
                       input bit ign, input logic [7:0] dat, input int low,
                       output int acc);
      int n = 0;
      acc = -1;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_addr = a; cmd_rw = rw; cmd_wdata = wd;
      while (!cmd_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) begin
         chk("push_accept", cmd_ready, 1);
         cmd_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         acc = cyc;
         expect_cmd(a, rw, wd, ign, dat, low);
         cmd_valid = 1'b0;
      end
   endtask

   task automatic drain(input int maxc);
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < maxc) begin
         @(negedge clk);
         n++;
      end
      chk("drain_done", (exp_q.size() == 0) && !busy, 1);
   endtask

   // Controller model: serves issues in order, shares rst with the DUT.
   initial begin : ctrl
      int    st;
      int    cnt;
      bit    en_prev;
      plan_t p;
      st = 0; cnt = 0; en_prev = 1'b0;
      i2c_ready = 1'b1;
      i2c_data_out = 8'h00;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            st = 0; en_prev = 1'b0; i2c_ready = 1'b1;
         end else begin
            if (en_prev && !i2c_enable) en_fall = cyc;
            case (st)
               0: if (i2c_enable && !en_prev) begin
                     en_rise = cyc;
                     chk("issue_has_plan", plan_q.size() != 0, 1);
                     if (plan_q.size() != 0) begin
                        p = plan_q.pop_front();
                        chk("issue_addr", i2c_addr, p.addr);
                        chk("issue_rw", i2c_rw, p.rw);
                        if (!p.rw) chk("issue_data", i2c_data_in, p.wd);
                        i2c_data_out = 8'($urandom);
                        if (!p.ign) begin
                           cnt = 4;
                           st = 1;
                        end
                     end
                  end
               1: begin
                     cnt--;
                     if (cnt == 0) begin
                        i2c_ready = 1'b0;
                        rf = cyc;
                        cnt = p.low;
                        st = 2;
                     end
                  end
               2: begin
                     cnt--;
                     if (cnt == 0) begin
                        i2c_data_out = p.dat;
                        i2c_ready = 1'b1;
                        st = 0;
                     end
                  end
               default: st = 0;
            endcase
            en_prev = i2c_enable;
         end
      end
   end

   // Response consumer.
   initial begin
      rsp_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rsp_mode)
            0:       rsp_ready = ($urandom % 3) != 0;
            1:       rsp_ready = 1'b0;
            default: rsp_ready = 1'b1;
         endcase
      end
   end

   // Monitor: compares each response against the scoreboard, checks hold.
   initial begin : mon
      bit         pend;
      logic [6:0] h_addr;
      logic [7:0] h_rdata;
      logic       h_to;
      exp_t       e;
      pend = 1'b0; h_addr = '0; h_rdata = '0; h_to = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            pend = 1'b0;
         end else if (rsp_valid) begin
            if (pend) begin
               chk("rsp_hold_addr", rsp_addr, h_addr);
               chk("rsp_hold_rdata", rsp_rdata, h_rdata);
               chk("rsp_hold_to", rsp_timeout, h_to);
            end
            chk("no_issue_while_rsp", i2c_enable, 0);
            h_addr = rsp_addr; h_rdata = rsp_rdata; h_to = rsp_timeout;
            if (rsp_ready) begin
               chk("rsp_has_expect", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk("rsp_addr", rsp_addr, e.addr);
                  chk("rsp_rdata", rsp_rdata, e.rdata);
                  chk("rsp_timeout", rsp_timeout, e.to);
               end
               hs_cyc = cyc + 1;
               rsp_cnt++;
               pend = 1'b0;
            end else begin
               pend = 1'b1;
            end
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
      $fatal(1, "watchdog");
   end

   initial begin : main
      int acc, rc, n, old, seen;
      bit prev;
      cmd_valid = 1'b0; cmd_addr = '0; cmd_rw = 1'b0; cmd_wdata = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_enable", i2c_enable, 0);
      chk("rst_i2c_addr", i2c_addr, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      rst = 1'b0;
      rsp_mode = 2;
      repeat (2) @(negedge clk);

      // Directed write 0x50 / 0xA5 with an 80-cycle controller busy window.
      rc = rsp_cnt;
      push(7'h50, 1'b0, 8'hA5, 1'b0, 8'h77, 80, acc);
      drain(2000);
      chk("wr_enable_latency", en_rise - acc, 1);
      chk("wr_enable_fall", en_fall - rf, 3);
      chk("wr_rsp_count", rsp_cnt - rc, 1);

      // Directed read 0x3C returning 0x5A.
      push(7'h3C, 1'b1, 8'h00, 1'b0, 8'h5A, 20, acc);
      drain(2000);

      // Six back-to-back offers while the head is stuck in ISSUE.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         cmd_valid = 1'b1;
         cmd_addr  = 7'h20 + 7'(i);
         cmd_rw    = 1'(i);
         cmd_wdata = 8'h30 + 8'(i);
         chk("b2b_cmd_ready", cmd_ready, (i < 4));
         if (cmd_ready) expect_cmd(cmd_addr, cmd_rw, cmd_wdata, (i == 0), 8'hC0 + 8'(i), 8 + i);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("b2b_head_issued", i2c_enable, 1);
      n = 0;
      prev = cmd_ready;
      while (!rsp_valid && n < 400) begin
         prev = cmd_ready;
         @(negedge clk);
         n++;
      end
      chk("to_rsp_seen", rsp_valid, 1);
      chk("to_latency", cyc - en_rise, TO);
      chk("to_full_before", prev, 0);
      chk("to_one_popped", cmd_ready, 1);
      drain(4000);

      // Response back-pressure with two commands queued behind it.
      rsp_mode = 1;
      push(7'h41, 1'b1, 8'h00, 1'b0, 8'h99, 10, acc);
      push(7'h42, 1'b0, 8'h5C, 1'b0, 8'h11, 12, acc);
      push(7'h43, 1'b1, 8'h00, 1'b0, 8'hE7, 9, acc);
      n = 0;
      while (!rsp_valid && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("bp_rsp_seen", rsp_valid, 1);
      repeat (20) begin
         @(negedge clk);
         chk("bp_valid_held", rsp_valid, 1);
         chk("bp_no_issue", i2c_enable, 0);
      end
      old = en_rise;
      rsp_mode = 2;
      n = 0;
      while (en_rise == old && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("bp_issue_gap", en_rise - hs_cyc, 2);
      drain(2000);

      // Reset while the controller is busy, three commands still queued.
      old = rf;
      push(7'h55, 1'b1, 8'h00, 1'b0, 8'h3A, 80, acc);
      push(7'h56, 1'b0, 8'h66, 1'b0, 8'h00, 20, acc);
      push(7'h57, 1'b0, 8'h67, 1'b0, 8'h00, 20, acc);
      push(7'h58, 1'b1, 8'h00, 1'b0, 8'h12, 20, acc);
      n = 0;
      while (!(rf != old && !i2c_enable) && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("rst_reached_busy", busy && !i2c_enable && (rf != old), 1);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_enable", i2c_enable, 0);
      chk("mid_rst_i2c_addr", i2c_addr, 0);
      chk("mid_rst_i2c_rw", i2c_rw, 0);
      chk("mid_rst_rsp_valid", rsp_valid, 0);
      chk("mid_rst_cmd_ready", cmd_ready, 1);
      chk("mid_rst_busy", busy, 0);
      plan_q.delete();
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (200) begin
         @(negedge clk);
         if (rsp_valid || i2c_enable) seen++;
      end
      chk("post_rst_silent", seen, 0);
      chk("post_rst_busy", busy, 0);

      // Randomised traffic with random back-pressure and occasional timeouts.
      rsp_mode = 0;
      for (int i = 0; i < 25; i++) begin
         repeat ($urandom % 3) @(negedge clk);
         push(7'($urandom), 1'($urandom), 8'($urandom), ($urandom % 6) == 0,
              8'($urandom), 6 + int'($urandom % 30), acc);
      end
      drain(20000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
